// File: rtl/rot_sched_pkg.sv
// Shared types and constants for the rot_sched round-robin rotate scheduler.
package rot_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam int DW = 8;
  localparam int AW = 3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/rot_core.sv
// Combinational 8-bit rotator; ROT_SCHED_LSHIFT_EN adds a mode input selecting
// a zero-fill logical shift instead of a rotate.
module rot_core
  import rot_sched_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [AW-1:0] amt,
  input  logic          dir,
`ifdef ROT_SCHED_LSHIFT_EN
  input  logic          mode,
`endif
  output logic [DW-1:0] y
);

  logic [2*DW-1:0] dbl;

  always_comb begin
    // Rotating a doubled copy turns wrap-around into a plain shift.
    dbl = {a, a};
    if (dir == DIR_LEFT) begin
      y = DW'((dbl << amt) >> DW);
    end else begin
      y = DW'(dbl >> amt);
    end
`ifdef ROT_SCHED_LSHIFT_EN
    if (mode) begin
      y = (dir == DIR_LEFT) ? (a << amt) : (a >> amt);
    end
`endif
  end

endmodule

// File: rtl/rot_sched.sv
// Round-robin scheduler sharing one rot_core among NREQ requesters.
// Optional macro ROT_SCHED_LSHIFT_EN adds the req_mode port (logical shift select).
module rot_sched
  import rot_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*AW-1:0] req_amt,
  input  logic [NREQ-1:0]    req_dir,
`ifdef ROT_SCHED_LSHIFT_EN
  input  logic [NREQ-1:0]    req_mode,
`endif
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic [IDW-1:0]     rsp_id
);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic [IDW-1:0] id_q;
  logic [DW-1:0]  a_q;
  logic [AW-1:0]  amt_q;
  logic           dir_q;
  logic [DW-1:0]  y;
`ifdef ROT_SCHED_LSHIFT_EN
  logic           mode_q;
`endif

  // Search upward from rr_ptr; IDW-bit wrap gives modulo NREQ for free.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready[win] = 1'b1;
    end
  end

  rot_core u_core (
    .a    (a_q),
    .amt  (amt_q),
    .dir  (dir_q),
`ifdef ROT_SCHED_LSHIFT_EN
    .mode (mode_q),
`endif
    .y    (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
      id_q      <= '0;
      a_q       <= '0;
      amt_q     <= '0;
      dir_q     <= 1'b0;
`ifdef ROT_SCHED_LSHIFT_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_q    <= req_data[DW*int'(win) +: DW];
            amt_q  <= req_amt[AW*int'(win) +: AW];
            dir_q  <= req_dir[win];
`ifdef ROT_SCHED_LSHIFT_EN
            mode_q <= req_mode[win];
`endif
            id_q   <= win;
            rr_ptr <= win + IDW'(1);
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= y;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_sched.sv
// Self-checking bench for rot_sched: directed steps plus randomized operations
// compared against an arithmetic reference model (ROT_SCHED_LSHIFT_EN aware).
module tb_rot_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_data = '0;
  logic [N*3-1:0] req_amt = '0;
  logic [N-1:0]   req_dir = '0;
`ifdef ROT_SCHED_LSHIFT_EN
  logic [N-1:0]   req_mode = '0;
`endif
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [7:0]     rsp_data;
  logic [1:0]     rsp_id;

  int errors = 0;
  int checks = 0;
  int ptr = 0;

  logic [7:0] d[N];
  int         am[N];
  logic       dr[N];
  logic       md[N];

  rot_sched #(.NREQ(N), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
`ifdef ROT_SCHED_LSHIFT_EN
    .req_mode  (req_mode),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: spec rotate/shift formulas in plain integer arithmetic.
  function automatic logic [7:0] ref_op(input logic [7:0] a, input int amt, input logic dir,
                                        input logic mode);
    int v;
    int r;
    v = int'(a);
    if (mode)
      r = dir ? ((v << amt) % 256) : (v >> amt);
    else if (dir)
      r = ((v << amt) | (v >> (8 - amt))) % 256;
    else
      r = ((v >> amt) | (v << (8 - amt))) % 256;
    return r[7:0];
  endfunction

  function automatic int ref_winner(input logic [N-1:0] vmask);
    for (int k = 0; k < N; k++) begin
      if (vmask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = d[i];
      req_amt[3*i +: 3]  = 3'(am[i]);
      req_dir[i]         = dr[i];
`ifdef ROT_SCHED_LSHIFT_EN
      req_mode[i]        = md[i];
`endif
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input int amt, input logic dir,
                         input logic mode);
    d[i]  = a;
    am[i] = amt;
    dr[i] = dir;
`ifdef ROT_SCHED_LSHIFT_EN
    md[i] = mode;
`else
    md[i] = 1'b0;
    if (mode) md[i] = 1'b0;
`endif
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr = 0;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    tick();
  endtask

  // One full transaction; req_valid stays asserted so consecutive calls are back-to-back.
  task automatic run_op(input logic [N-1:0] vmask, input int hold);
    int w;
    logic [7:0] e;
    req_valid = vmask;
    apply();
    rsp_ready = (hold == 0);
    #1;
    w = ref_winner(vmask);
    e = ref_op(d[w], am[w], dr[w], md[w]);
    chk("grant", 32'(req_ready), 32'(1) << w);
    tick();
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(e));
    chk("rsp_id", 32'(rsp_id), 32'(w));
    chk("resp_ready", 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(e));
      chk("hold_id", 32'(rsp_id), 32'(w));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    if (hold > 0) begin
      rsp_ready = 1'b1;
      #1;
      chk("hs_ready", 32'(req_ready), 32'd0);
    end
    tick();
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    ptr = (w + 1) % N;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_req(i, 8'h00, 0, 1'b0, 1'b0);
    do_reset();

    // Single request from requester 0: ror 1 of 0xB1.
    set_req(0, 8'hB1, 1, 1'b0, 1'b0);
    run_op(4'b0001, 0);

    // Requester 2: rol, amt=4 both ways, amt=0 pass-through.
    set_req(2, 8'h81, 3, 1'b1, 1'b0);
    run_op(4'b0100, 0);
    set_req(2, 8'hA5, 4, 1'b1, 1'b0);
    run_op(4'b0100, 0);
    set_req(2, 8'hA5, 4, 1'b0, 1'b0);
    run_op(4'b0100, 0);
    set_req(2, 8'hA5, 0, 1'b1, 1'b0);
    run_op(4'b0100, 0);

`ifdef ROT_SCHED_LSHIFT_EN
    set_req(1, 8'hB1, 1, 1'b0, 1'b1);
    run_op(4'b0010, 0);
    set_req(1, 8'hB1, 1, 1'b0, 1'b0);
    run_op(4'b0010, 0);
    set_req(1, 8'h81, 3, 1'b1, 1'b1);
    run_op(4'b0010, 0);
`endif

    // Round-robin from a fresh pointer with all requesters busy.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h11 * (i + 3)), i + 1, 1'(i % 2), 1'b0);
    for (int g = 0; g < 5; g++) run_op(4'b1111, 0);

    // Single active requester granted back-to-back.
    run_op(4'b0010, 0);
    run_op(4'b0010, 0);

    // Backpressure for 5 cycles.
    set_req(3, 8'h3C, 5, 1'b1, 1'b0);
    run_op(4'b1000, 5);
    req_valid = '0;

    // Reset during RESP: rsp_valid drops asynchronously, pointer restarts.
    set_req(2, 8'hC3, 2, 1'b0, 1'b0);
    req_valid = 4'b0100;
    apply();
    rsp_ready = 1'b0;
    #1;
    chk("pre_rst_grant", 32'(req_ready), 32'(1) << ref_winner(4'b0100));
    tick();
    tick();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rsp_valid), 32'd0);
    chk("rst_async_data", 32'(rsp_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr = 0;
    set_req(3, 8'h96, 6, 1'b1, 1'b0);
    run_op(4'b1100, 0);

    // Reset during EXEC: result must never appear.
    req_valid = 4'b0001;
    apply();
    rsp_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    req_valid = '0;
    chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr = 0;
    tick();
    chk("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);

    // Randomized operations.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, 8'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      end
      run_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rot_sched.md
Name: rot_sched

Overview:
- Round-robin scheduler that time-shares one 8-bit rotate datapath among NREQ requesters.
- Each requester presents operand, amount and direction on a valid/ready handshake. The block arbitrates, drives the shared rotator, and returns the result tagged with the requester ID on a valid/ready response channel.
- Sits between per-lane command sources and the shared shift resource.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..8.
- IDW, 2, requester ID width; must equal log2(NREQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- req_data  in  NREQ*8  operands; requester i occupies bits [8i+7:8i].
- req_amt  in  NREQ*3  rotate amounts; requester i occupies bits [3i+2:3i].
- req_dir  in  NREQ  0 = rotate right, 1 = rotate left.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_data  out  8  rotated result.
- rsp_id  out  IDW  index of the requester that owns rsp_data.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Encoding is taken from the shared package.
- Reset (async assert, sync deassert by design): state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, operand latches=0. Any in-flight request is discarded with no response.

IDLE:
- req_ready is combinational: one-hot on the winner when any req_valid is high, else all zero.
- Winner is the first valid requester searching upward from rr_ptr, wrapping modulo NREQ.
- On the handshake (req_valid[g] & req_ready[g]): latch data, amt, dir and g; set rr_ptr = g+1 mod NREQ; go to EXEC.

EXEC:
- req_ready = 0.
- Register rotator output into rsp_data and g into rsp_id; go to RESP.

RESP:
- rsp_valid = 1, req_ready = 0.
- rsp_data and rsp_id stay stable until rsp_ready.
- On rsp_ready: rsp_valid = 0 next cycle; go to IDLE.
- A new grant is not issued in the same cycle as the response handshake.

Rotate arithmetic:
- dir=0 rotate right: y = (a >> amt) | (a << (8-amt)).
- dir=1 rotate left: y = (a << amt) | (a >> (8-amt)).
- amt=0 passes the operand through; amt=4 gives the same result in either direction.

Timing and fairness:
- Latency: handshake in cycle t → rsp_valid in cycle t+2.
- Throughput: at most one op per 3 cycles with rsp_ready held high.
- Fairness: under continuous demand every requester is granted within NREQ grants.
- A requester may drop req_valid before its grant; no state is kept for it.

Boundary conditions:
- rr_ptr wraps from NREQ-1 to 0.
- A single active requester is granted back-to-back.
- rsp_ready high outside RESP is ignored.
- Reset asserted in EXEC or RESP clears rsp_valid immediately (async) and the result is lost.

Optional Feature:
- Macro: ROT_SCHED_LSHIFT_EN.
- When defined:
  - Extra input port req_mode [NREQ], latched with the operand.
  - mode=1 selects a logical shift with zero fill, in the direction given by dir.
  - mode=0 selects rotate.
- When undefined:
  - The req_mode port is absent.
  - All operations are rotates.
  - Logic is identical to the mode=0 path.

Decomposition:
- Shared package rot_sched_pkg holds:
  - state enum (IDLE, EXEC, RESP);
  - localparams DW=8 and AW=3;
  - direction constants DIR_RIGHT=0 and DIR_LEFT=1.
- Sub-module rot_core: purely combinational 8-bit rotator with inputs a, amt, dir (plus mode under ROT_SCHED_LSHIFT_EN) and output y.
- rot_sched instantiates rot_core once, fed from the operand latches.

Test Plan:
- Single request, req0: data=0xB1, amt=1, dir=0, rsp_ready=1 → req_ready=0001 in cycle t; rsp_valid in t+2 with rsp_data=0xD8, rsp_id=0.
- Rotate left, req2: 0x81, amt=3, dir=1 → rsp_data=0x0C, rsp_id=2. Then 0xA5, amt=4, both directions → 0x5A. Then amt=0 → 0xA5.
- Round-robin: all four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0, one grant every 3 cycles; req_ready never multi-hot.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout; IDLE re-entered one cycle after rsp_ready rises.
- Reset mid-op: assert rst_n=0 during EXEC → rsp_valid=0 immediately; after release, rr_ptr=0 and the next grant goes to the lowest valid index.
- ROT_SCHED_LSHIFT_EN defined: 0xB1, amt=1, dir=0, mode=1 → 0x58; same stimulus with mode=0 → 0xD8.
